mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the shared memory port.
// The arbiter connects through the slave modport; the requesters/memory model use master.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_size;
    logic        ls_ack;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size, mem_rdata,
        output if_ack, if_rdata, ls_ack, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_size
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size, mem_rdata,
        input  if_ack, if_rdata, ls_ack, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single fixed-latency memory port.
// Define ARB_RR_EN for round-robin contention; otherwise ls has priority with a fetch starve guard.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_LS, OWN_IF} owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } txn_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    // A fetch is always a full 32-bit word access.
    localparam logic [2:0] FETCH_SIZE = 3'd2;

    state_t      state, state_nx;
    logic [3:0]  lat_cnt;
    owner_t      owner;
    txn_t        txn;
    logic [31:0] rdata_q;
    logic        grant_any;
    logic        grant_if;

    assign grant_any = bus.if_req | bus.ls_req;

`ifdef ARB_RR_EN
    owner_t last_grant;

    assign grant_if = bus.if_req & (~bus.ls_req | (last_grant == OWN_LS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_LS;
        end else if (state == IDLE && grant_any) begin
            last_grant <= grant_if ? OWN_IF : OWN_LS;
        end
    end
`else
    logic [3:0] starve_cnt;
    logic       starved;

    assign starved  = (starve_cnt >= 4'(STARVE_MAX));
    assign grant_if = bus.if_req & (~bus.ls_req | starved);

    // Counts consecutive grants that fetch lost while it was asking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!bus.if_req || grant_if) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx      = state;
        busy          = (state != IDLE);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        bus.if_ack    = 1'b0;
        bus.if_rdata  = '0;
        bus.ls_ack    = 1'b0;
        bus.ls_rdata  = '0;
        unique case (state)
            IDLE: begin
                if (grant_any) state_nx = ACCESS;
            end
            ACCESS: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = txn.we;
                bus.mem_addr  = txn.addr;
                bus.mem_wdata = txn.wdata;
                bus.mem_size  = txn.size;
                if (lat_cnt == 4'd0) state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
                if (owner == OWN_IF) begin
                    bus.if_ack   = 1'b1;
                    bus.if_rdata = rdata_q;
                end else begin
                    bus.ls_ack   = 1'b1;
                    bus.ls_rdata = rdata_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            owner   <= OWN_LS;
            txn     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        lat_cnt <= LAT_INIT;
                        owner   <= grant_if ? OWN_IF : OWN_LS;
                        if (grant_if) begin
                            txn <= '{we: 1'b0, addr: bus.if_addr, wdata: 32'd0, size: FETCH_SIZE};
                        end else begin
                            txn <= '{we: bus.ls_we, addr: bus.ls_addr,
                                     wdata: bus.ls_wdata, size: bus.ls_size};
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt == 4'd0) begin
                        rdata_q <= txn.we ? 32'd0 : bus.mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
